// File: rtl/controle_irrigacao.sv
// Irrigation valve controller: drip / sprinkler bursts with soak pause,
// fault lockout on low tank or invalid moisture, burst counter.
module controle_irrigacao #(
    parameter int N_GOT   = 8,
    parameter int N_ASP   = 4,
    parameter int N_PAUSA = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_gotejar,
    input  logic       f_aspersao,
    input  logic [1:0] umidade,
    input  logic       tanque_baixo,
    input  logic       rearme,
    output logic       valvula_got,
    output logic       valvula_asp,
    output logic       erro,
    output logic [2:0] estado,
    output logic [7:0] ciclos
);

    typedef enum logic [2:0] {
        OCIOSO     = 3'b000,
        GOTEJANDO  = 3'b001,
        ASPERSANDO = 3'b010,
        PAUSA      = 3'b011,
        ERRO       = 3'b100
    } state_t;

    localparam logic [7:0] L_GOT   = 8'(N_GOT);
    localparam logic [7:0] L_ASP   = 8'(N_ASP);
    localparam logic [7:0] L_PAUSA = 8'(N_PAUSA);

    localparam logic [1:0] UM_SECO   = 2'b00;
    localparam logic [1:0] UM_MEDIO  = 2'b01;
    localparam logic [1:0] UM_INVAL  = 2'b10;
    localparam logic [1:0] UM_MOLHADO = 2'b11;

    // bit map: 0 f_got, 1 f_asp, 3:2 umidade, 4 tanque, 5 rearme
    logic [5:0] w_in;
    logic [5:0] r_s1;
    logic [5:0] r_s2;

    logic r_got_d;
    logic r_asp_d;
    logic r_tick_got;
    logic r_tick_asp;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt;
    logic [7:0] w_cnt_p1;
    logic [7:0] r_ciclos;
    logic       w_inc;

    logic       r_vg;
    logic       r_va;
    logic       r_erro;

    logic [1:0] w_um;
    logic       w_tb;
    logic       w_rearme;
    logic       w_fault;

    assign w_in = {rearme, tanque_baixo, umidade, f_aspersao, f_gotejar};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
        end
    end

    // Tick pulses are registered so every decision sees a clean one-cycle strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_got_d    <= 1'b0;
            r_asp_d    <= 1'b0;
            r_tick_got <= 1'b0;
            r_tick_asp <= 1'b0;
        end else begin
            r_got_d    <= r_s2[0];
            r_asp_d    <= r_s2[1];
            r_tick_got <= r_s2[0] & ~r_got_d;
            r_tick_asp <= r_s2[1] & ~r_asp_d;
        end
    end

    assign w_um     = r_s2[3:2];
    assign w_tb     = r_s2[4];
    assign w_rearme = r_s2[5];
    assign w_fault  = w_tb | (w_um == UM_INVAL);
    assign w_cnt_p1 = r_cnt + 8'd1;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        if (w_fault) begin
            w_next = ERRO;
            w_cnt  = '0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    w_cnt = '0;
                    if (w_um == UM_SECO)
                        w_next = ASPERSANDO;
                    else if (w_um == UM_MEDIO)
                        w_next = GOTEJANDO;
                end
                GOTEJANDO: begin
                    if (w_um == UM_MOLHADO) begin
                        w_next = PAUSA;
                        w_cnt  = '0;
                    end else if (r_tick_got) begin
                        if (w_cnt_p1 == L_GOT) begin
                            w_next = PAUSA;
                            w_cnt  = '0;
                        end else begin
                            w_cnt = w_cnt_p1;
                        end
                    end
                end
                ASPERSANDO: begin
                    if (w_um == UM_MOLHADO) begin
                        w_next = PAUSA;
                        w_cnt  = '0;
                    end else if (r_tick_asp) begin
                        if (w_cnt_p1 == L_ASP) begin
                            w_next = PAUSA;
                            w_cnt  = '0;
                        end else begin
                            w_cnt = w_cnt_p1;
                        end
                    end
                end
                PAUSA: begin
                    if (r_tick_got) begin
                        if (w_cnt_p1 == L_PAUSA) begin
                            w_next = OCIOSO;
                            w_cnt  = '0;
                        end else begin
                            w_cnt = w_cnt_p1;
                        end
                    end
                end
                ERRO: begin
                    if (w_rearme) begin
                        w_next = OCIOSO;
                        w_cnt  = '0;
                    end
                end
                default: begin
                    w_next = ERRO;
                    w_cnt  = '0;
                end
            endcase
        end
    end

    // One increment per entry, however PAUSA was reached
    assign w_inc = (w_next == PAUSA) && (r_state != PAUSA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= OCIOSO;
            r_cnt    <= '0;
            r_ciclos <= '0;
            r_vg     <= 1'b0;
            r_va     <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (w_inc && (r_ciclos != 8'hFF))
                r_ciclos <= r_ciclos + 8'd1;
            r_vg   <= (w_next == GOTEJANDO);
            r_va   <= (w_next == ASPERSANDO);
            r_erro <= (w_next == ERRO);
        end
    end

    assign valvula_got = r_vg;
    assign valvula_asp = r_va;
    assign erro        = r_erro;
    assign estado      = r_state;
    assign ciclos      = r_ciclos;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao: drip, sprinkler, fault lockout,
// simultaneous final tick / wet, ciclos saturation and async reset.
module tb_controle_irrigacao;

    logic       clk;
    logic       rst;
    logic       f_gotejar;
    logic       f_aspersao;
    logic [1:0] umidade;
    logic       tanque_baixo;
    logic       rearme;
    logic       valvula_got;
    logic       valvula_asp;
    logic       erro;
    logic [2:0] estado;
    logic [7:0] ciclos;

    int n_chk = 0;
    int n_ok  = 0;
    int cic   = 0;

    controle_irrigacao #(.N_GOT(8), .N_ASP(4), .N_PAUSA(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_gotejar   (f_gotejar),
        .f_aspersao  (f_aspersao),
        .umidade     (umidade),
        .tanque_baixo(tanque_baixo),
        .rearme      (rearme),
        .valvula_got (valvula_got),
        .valvula_asp (valvula_asp),
        .erro        (erro),
        .estado      (estado),
        .ciclos      (ciclos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_um(input logic [1:0] v);
        @(negedge clk);
        umidade = v;
        wait_n(3);
    endtask

    task automatic tick_got();
        @(negedge clk);
        f_gotejar = 1'b1;
        wait_n(3);
        f_gotejar = 1'b0;
        wait_n(3);
    endtask

    task automatic tick_asp();
        @(negedge clk);
        f_aspersao = 1'b1;
        wait_n(3);
        f_aspersao = 1'b0;
        wait_n(3);
    endtask

    initial begin
        rst          = 1'b0;
        f_gotejar    = 1'b0;
        f_aspersao   = 1'b0;
        umidade      = 2'b11;
        tanque_baixo = 1'b0;
        rearme       = 1'b0;
        wait_n(3);
        check("rst_estado", 32'(estado), 0);
        check("rst_vg", 32'(valvula_got), 0);
        check("rst_va", 32'(valvula_asp), 0);
        check("rst_erro", 32'(erro), 0);
        check("rst_ciclos", 32'(ciclos), 0);

        // Synchronizers leave reset reading 00 (dry): one short burst, ended wet
        @(negedge clk);
        rst = 1'b1;
        wait_n(4);
        cic = 1;
        check("boot_pausa", 32'(estado), 3);
        check("boot_ciclos", 32'(ciclos), 32'(cic));
        tick_got();
        tick_got();
        check("boot_ocioso", 32'(estado), 0);

        // Drip burst of 8 ticks, then 2-tick pause
        set_um(2'b01);
        check("got_estado", 32'(estado), 1);
        check("got_vg", 32'(valvula_got), 1);
        check("got_va", 32'(valvula_asp), 0);
        repeat (7) tick_got();
        check("got_7", 32'(estado), 1);
        tick_got();
        cic++;
        check("got_8_pausa", 32'(estado), 3);
        check("got_8_vg", 32'(valvula_got), 0);
        check("got_ciclos", 32'(ciclos), 32'(cic));
        set_um(2'b11);
        tick_got();
        check("pausa_1", 32'(estado), 3);
        tick_got();
        check("pausa_2", 32'(estado), 0);

        // Sprinkler burst, moisture goes medium midway
        set_um(2'b00);
        check("asp_estado", 32'(estado), 2);
        check("asp_va", 32'(valvula_asp), 1);
        check("asp_vg", 32'(valvula_got), 0);
        tick_asp();
        tick_asp();
        set_um(2'b01);
        check("asp_medio", 32'(estado), 2);
        tick_asp();
        check("asp_3", 32'(estado), 2);
        tick_asp();
        cic++;
        check("asp_4_pausa", 32'(estado), 3);
        check("asp_ciclos", 32'(ciclos), 32'(cic));
        set_um(2'b11);
        tick_asp();
        check("pausa_asp_ign", 32'(estado), 3);
        tick_got();
        tick_got();
        check("asp_ocioso", 32'(estado), 0);

        // Low tank during drip, rearme gated by fault
        set_um(2'b01);
        repeat (3) tick_got();
        @(negedge clk);
        tanque_baixo = 1'b1;
        wait_n(3);
        check("tq_estado", 32'(estado), 4);
        check("tq_erro", 32'(erro), 1);
        check("tq_vg", 32'(valvula_got), 0);
        set_um(2'b11);
        rearme = 1'b1;
        wait_n(3);
        check("tq_rearme_blk", 32'(estado), 4);
        rearme = 1'b0;
        tanque_baixo = 1'b0;
        wait_n(3);
        check("tq_clear", 32'(estado), 4);
        rearme = 1'b1;
        wait_n(3);
        rearme = 1'b0;
        check("tq_rearme", 32'(estado), 0);
        check("tq_erro0", 32'(erro), 0);
        check("tq_ciclos", 32'(ciclos), 32'(cic));

        // Final tick and wet together: single PAUSA entry
        set_um(2'b01);
        repeat (7) tick_got();
        check("cnt_cleared", 32'(estado), 1);
        @(negedge clk);
        f_gotejar = 1'b1;
        @(negedge clk);
        umidade = 2'b11;
        wait_n(2);
        f_gotejar = 1'b0;
        wait_n(3);
        cic++;
        check("sim_pausa", 32'(estado), 3);
        check("sim_ciclos", 32'(ciclos), 32'(cic));
        tick_got();
        tick_got();
        check("sim_ocioso", 32'(estado), 0);
        check("sim_ciclos2", 32'(ciclos), 32'(cic));

        // 300 early-terminated bursts
        for (int i = 0; i < 300; i++) begin
            set_um(2'b01);
            set_um(2'b11);
            tick_got();
            tick_got();
            if (cic < 255) cic++;
            if (i == 99)
                check("sat_100", 32'(ciclos), 32'(cic));
        end
        check("sat_255", 32'(ciclos), 255);
        check("sat_ocioso", 32'(estado), 0);
        set_um(2'b01);
        set_um(2'b11);
        check("sat_pausa", 32'(estado), 3);
        check("sat_hold", 32'(ciclos), 255);
        set_um(2'b10);
        check("inval_erro", 32'(estado), 4);
        check("inval_erro_o", 32'(erro), 1);
        set_um(2'b11);
        rearme = 1'b1;
        wait_n(3);
        rearme = 1'b0;
        check("inval_rearme", 32'(estado), 0);

        // Asynchronous reset between edges mid-sprinkle
        set_um(2'b00);
        check("ar_asp", 32'(valvula_asp), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_va", 32'(valvula_asp), 0);
        check("ar_estado", 32'(estado), 0);
        check("ar_ciclos", 32'(ciclos), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_n(4);
        check("ar_restart", 32'(estado), 2);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/controle_irrigacao.md
CONTROLE_IRRIGACAO -- requirements
Module: controle_irrigacao

Interface
REQ-001 SHALL have parameter N_GOT, default 8: f_gotejar ticks per drip burst (1..255).
REQ-002 SHALL have parameter N_ASP, default 4: f_aspersao ticks per sprinkler burst (1..255).
REQ-003 SHALL have parameter N_PAUSA, default 2: f_gotejar ticks of soak pause after a burst (1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; every flop is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port f_gotejar, input, 1 bit: drip-rate square wave from the frequency divider; each rising edge is one drip tick.
REQ-007 SHALL have port f_aspersao, input, 1 bit: sprinkler-rate square wave from the frequency divider; each rising edge is one sprinkler tick.
REQ-008 SHALL have port umidade, input, 2 bits: soil moisture, where 00 = dry, 01 = medium, 11 = wet, and 10 = invalid.
REQ-009 SHALL have port tanque_baixo, input, 1 bit: water tank below minimum.
REQ-010 SHALL have port rearme, input, 1 bit: operator acknowledge used to leave ERRO.
REQ-011 SHALL have port valvula_got, output, 1 bit: drip valve open.
REQ-012 SHALL have port valvula_asp, output, 1 bit: sprinkler valve open.
REQ-013 SHALL have port erro, output, 1 bit: fault indication.
REQ-014 SHALL have port estado, output, 3 bits: current FSM state.
REQ-015 SHALL have port ciclos, output, 8 bits: count of completed irrigation bursts.

Function
REQ-016 SHALL pass f_gotejar, f_aspersao, umidade, tanque_baixo and rearme each through a 2-flop synchronizer; all decisions SHALL use only the synchronized values.
REQ-017 SHALL generate tick_got and tick_asp as one-cycle pulses on rising edges of the synchronized waves (sync output AND NOT its delayed copy).
- Latency: an input change sampled at edge k affects state, counter and outputs at edge k+2 (levels) or k+3 (ticks).
REQ-018 SHALL use states OCIOSO=000, GOTEJANDO=001, ASPERSANDO=010, PAUSA=011, ERRO=100; the codes 101–111 SHALL go to ERRO on the next edge.
REQ-019 SHALL give the ERRO transition the highest priority: from any state, synchronized tanque_baixo=1 or umidade=10 SHALL go to ERRO on the next edge and clear the tick counter.
REQ-020 SHALL leave ERRO for OCIOSO only when rearme=1 and both fault conditions are clear in the same cycle; rearme in any other state SHALL be ignored.
REQ-021 SHALL, in OCIOSO, go to ASPERSANDO when umidade=00, go to GOTEJANDO when umidade=01, and stay in OCIOSO when umidade=11; on entry to OCIOSO the counter SHALL be 0.
REQ-022 SHALL, in GOTEJANDO, increment an 8-bit counter on each tick_got; the tick_got that brings the count to N_GOT SHALL move the FSM to PAUSA and zero the counter.
REQ-023 SHALL, in ASPERSANDO, behave as in REQ-022 but using tick_asp and N_ASP; umidade=01 while in ASPERSANDO SHALL NOT change the mode.
REQ-024 SHALL go to PAUSA from GOTEJANDO or ASPERSANDO immediately (next edge) when umidade=11, zeroing the counter (early termination).
REQ-025 SHALL, in PAUSA, count tick_got and go to OCIOSO on the tick that reaches N_PAUSA; the tick_asp input SHALL be ignored in PAUSA.
REQ-026 SHALL increment ciclos once on every entry to PAUSA, whether by completion or early termination, and SHALL saturate ciclos at 255.
REQ-027 SHALL, when a final tick and umidade=11 occur in the same cycle, enter PAUSA once and increment ciclos by 1.
REQ-028 SHALL register all outputs; valvula_got=1 iff in GOTEJANDO, valvula_asp=1 iff in ASPERSANDO, erro=1 iff in ERRO; both valves SHALL never be 1 together.

Reset
REQ-029 SHALL, while rst=0, immediately force: state OCIOSO, estado=000, counter=0, ciclos=0, valves=0, erro=0, and all synchronizer and edge flops=0.
REQ-030 SHALL, when reset is asserted mid-burst, close the valves without waiting for a clock edge, and SHALL restart from OCIOSO after rst returns to 1.

Verification
REQ-031 SHALL verify this case: umidade=01, N_GOT=8 → valvula_got=1 for exactly 8 tick_got, then PAUSA for 2 tick_got, then OCIOSO, and ciclos=1.
REQ-032 SHALL verify this case: umidade=00 → ASPERSANDO, valvula_asp=1 for 4 tick_asp; umidade changed to 01 mid-burst → burst still completes; ciclos=1.
REQ-033 SHALL verify this case: tanque_baixo=1 during GOTEJANDO → estado=100, erro=1 and valves=0 within 3 edges; rearme=1 while tanque_baixo=1 → stays in ERRO; tanque_baixo=0 then rearme=1 → OCIOSO.
REQ-034 SHALL verify this case: umidade=11 on the same cycle as the 8th tick_got → a single PAUSA entry and ciclos incremented by exactly 1.
REQ-035 SHALL verify this case: 300 forced bursts → ciclos=255 held; umidade=10 in PAUSA → ERRO.
REQ-036 SHALL verify this case: rst=0 asserted between clock edges during ASPERSANDO → valvula_asp=0 immediately and estado=000.
